// File: rtl/hazard_ctrl_unit.sv
// ---------------------------------------------------------------------------------------------
// hazard_ctrl_unit
//
// Hazard controller for the 5-stage pipeline (fetch/decode/execute/memory/writeback).
// It sits beside the stage modules, takes their register indices and control bits and drives
// their stall/flush enables.
//
// Functions:
//   - EX-stage operand forwarding selects (Memory result beats Writeback result).
//   - Load-use stall: a load in Execute whose destination is read by the Decode instruction.
//   - Branch/jump flush when Execute resolves a taken control transfer.
//   - Multi-cycle data-memory wait: a load reaching Memory freezes the whole pipe for
//     MEM_LAT-1 cycles. A small RUN/MEM_WAIT FSM with a down-counter tracks the wait.
//   - Saturating performance counters for stall cycles and flush cycles.
//
// Parameters:
//   REG_AW   register index width; index 0 is the hard-wired zero register
//   MEM_LAT  data-memory load latency in cycles, legal 1..8 (1 = single-cycle memory)
//   CNT_W    performance counter width
//
// Ports:
//   clk, rst                       clock (rising edge), asynchronous active-low reset
//   rs1_d, rs2_d                   Decode source registers
//   rs1_e, rs2_e, rd_e             Execute sources / destination
//   regwrite_e, resultsrc_e        Execute writes a register / is a load
//   rd_m, regwrite_m, resultsrc_m  Memory destination / writes a register / is a load
//   rd_w, regwrite_w               Writeback destination / writes a register
//   pcsrc_e                        taken branch/jump in Execute
//   clr_cnt                        synchronous clear of both performance counters
//   forward_a_e, forward_b_e       ALU operand selects: 00 regfile, 10 Memory, 01 Writeback
//   stall_f/d/e/m                  hold PC / D / E / M pipeline registers
//   flush_d, flush_e               bubble D / E pipeline registers
//   mem_busy                       FSM is in MEM_WAIT
//   stall_cnt, flush_cnt           saturating cycle counters of stall_f and flush_d
// ---------------------------------------------------------------------------------------------
module hazard_ctrl_unit #(
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rs1_e,
    input  logic [REG_AW-1:0] rs2_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic              regwrite_e,
    input  logic              resultsrc_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic              regwrite_m,
    input  logic              resultsrc_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              regwrite_w,
    input  logic              pcsrc_e,
    input  logic              clr_cnt,

    output logic [1:0]        forward_a_e,
    output logic [1:0]        forward_b_e,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              stall_m,
    output logic              flush_d,
    output logic              flush_e,
    output logic              mem_busy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    // Wait counter holds at most MEM_LAT-2 = 6 for the largest legal latency.
    localparam int unsigned       WcntW      = 3;
    localparam logic [WcntW-1:0]  WaitInit   = WcntW'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);
    localparam logic              MultiCycle = (MEM_LAT > 1);
    localparam logic [CNT_W-1:0]  CntMax     = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        StRun,
        StMemWait
    } state_e;

    state_e            state_q, state_d;
    logic [WcntW-1:0]  wcnt_q, wcnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic              lw_stall;
    logic              mem_stall;
    logic              load_in_m;

    // -----------------------------------------------------------------------------------------
    // Forwarding
    // -----------------------------------------------------------------------------------------
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rdm,
        input logic              wm,
        input logic [REG_AW-1:0] rdw,
        input logic              ww
    );
        logic [1:0] sel;
        sel = 2'b00;
        // The zero register never forwards: its value is a constant, not a pipeline result.
        if (rs != '0) begin
            if (wm && (rdm == rs)) begin
                sel = 2'b10;
            end else if (ww && (rdw == rs)) begin
                sel = 2'b01;
            end
        end
        return sel;
    endfunction

    always_comb begin
        forward_a_e = fwd_sel(rs1_e, rd_m, regwrite_m, rd_w, regwrite_w);
        forward_b_e = fwd_sel(rs2_e, rd_m, regwrite_m, rd_w, regwrite_w);
    end

    // -----------------------------------------------------------------------------------------
    // Stall conditions
    // -----------------------------------------------------------------------------------------
    assign load_in_m = resultsrc_m & regwrite_m;

    always_comb begin
        lw_stall = resultsrc_e && regwrite_e && (rd_e != '0) &&
                   ((rd_e == rs1_d) || (rd_e == rs2_d));
    end

    // Gated by rst so that asserting reset mid-wait releases the pipe without a clock edge,
    // even while the load is still presented at the Memory stage.
    always_comb begin
        mem_stall = 1'b0;
        if (rst) begin
            unique case (state_q)
                StRun:     mem_stall = MultiCycle && load_in_m;
                StMemWait: mem_stall = (wcnt_q != '0);
                default:   mem_stall = 1'b0;
            endcase
        end
    end

    // -----------------------------------------------------------------------------------------
    // Memory-wait FSM
    // -----------------------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        unique case (state_q)
            StRun: begin
                if (mem_stall) begin
                    state_d = StMemWait;
                    wcnt_d  = WaitInit;
                end
            end
            StMemWait: begin
                // wcnt==0 is the release cycle: stalls are already low and the load leaves M.
                if (wcnt_q != '0) begin
                    wcnt_d = wcnt_q - 1'b1;
                end else begin
                    state_d = StRun;
                end
            end
            default: begin
                state_d = StRun;
                wcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StRun;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Stall / flush outputs
    // -----------------------------------------------------------------------------------------
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        if (mem_stall) begin
            // Whole-pipe freeze; a pending branch or load-use hazard is held in place and acted
            // on once the freeze lifts.
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
        end else begin
            stall_f = lw_stall;
            stall_d = lw_stall;
            // A taken branch also squashes the instruction a load-use stall would have held.
            flush_d = pcsrc_e;
            flush_e = pcsrc_e | lw_stall;
        end
    end

    // High through the release cycle as well, since the FSM is still in MEM_WAIT there.
    assign mem_busy = (state_q == StMemWait);

    // -----------------------------------------------------------------------------------------
    // Performance counters
    // -----------------------------------------------------------------------------------------
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (clr_cnt) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall_f && (stall_cnt_q != CntMax)) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if (flush_d && (flush_cnt_q != CntMax)) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
